// File: rtl/jt5205_adpcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jt5205_adpcm_pkg
//  Description : Shared OKI ADPCM tables, limits and stage types.
//  Revision    : 1.0 - initial release
// ============================================================================
package jt5205_adpcm_pkg;

    localparam logic [5:0]         IDX_MAX = 6'd48;
    localparam logic signed [11:0] SND_MAX = 12'sd2047;
    localparam logic signed [11:0] SND_MIN = -12'sd2048;

    localparam logic [10:0] STEP_TAB [0:48] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [4:0] ADJ_TAB [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef logic signed [11:0] sample_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  nib;
        logic [10:0] step;
    } stage1_t;

    // Saturating step-index update; never wraps past either end.
    function automatic logic [5:0] idx_next(input logic [5:0] idx, input logic [2:0] mag);
        logic signed [7:0] t;
        t = $signed({2'b00, idx}) + 8'(ADJ_TAB[mag]);
        if (t < 8'sd0) begin
            return 6'd0;
        end else if (t > $signed({2'b00, IDX_MAX})) begin
            return IDX_MAX;
        end
        return t[5:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt5205_adpcm_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt5205_adpcm_if
//  Description : Nibble/sample bus between timing stage and ADPCM decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jt5205_adpcm_if;
    import jt5205_adpcm_pkg::*;

    logic       cen_lo;
    logic [3:0] din;
    logic       pause;
    sample_t    sound;
    logic       sample_ok;

    modport master (
        output cen_lo,
        output din,
        output pause,
        input  sound,
        input  sample_ok
    );

    modport slave (
        input  cen_lo,
        input  din,
        input  pause,
        output sound,
        output sample_ok
    );
endinterface
`default_nettype wire

// File: rtl/jt5205_steptab.sv
`default_nettype none
// ============================================================================
//  Module      : jt5205_steptab
//  Description : Combinational step-size ROM, 6-bit index to 11-bit step.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt5205_steptab
    import jt5205_adpcm_pkg::*;
(
    input  wire logic [5:0]  i_idx,
    output logic      [10:0] o_step
);

    // Unused codes above 48 map to the last entry so the ROM stays fully defined.
    always_comb begin
        o_step = STEP_TAB[48];
        if (i_idx <= IDX_MAX) begin
            o_step = STEP_TAB[i_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/jt5205_adpcm.sv
`default_nettype none
// ============================================================================
//  Module      : jt5205_adpcm
//  Description : Two-stage pipelined OKI MSM5205 ADPCM nibble decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt5205_adpcm
    import jt5205_adpcm_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    jt5205_adpcm_if.slave   bus
);

    logic [5:0]  r_idx;
    stage1_t     r_s1;
    sample_t     r_snd;
    logic        r_sample_ok;

    logic [10:0]        w_step;
    logic [5:0]         w_idx_next;
    logic [12:0]        w_delta;
    logic signed [13:0] w_sum;
    sample_t            w_snd_next;

    jt5205_steptab u_steptab (
        .i_idx  (r_idx),
        .o_step (w_step)
    );

    assign w_idx_next = idx_next(r_idx, bus.din[2:0]);

    // Stage 1: capture nibble and its step, advance the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_s1  <= '0;
        end else if (bus.pause) begin
            r_idx    <= '0;
            r_s1.valid <= 1'b0;
        end else begin
            r_s1.valid <= bus.cen_lo;
            if (bus.cen_lo) begin
                r_s1.nib  <= bus.din;
                r_s1.step <= w_step;
                r_idx     <= w_idx_next;
            end
        end
    end

    always_comb begin
        w_delta = 13'(r_s1.step >> 3);
        if (r_s1.nib[0]) begin
            w_delta = w_delta + 13'(r_s1.step >> 2);
        end
        if (r_s1.nib[1]) begin
            w_delta = w_delta + 13'(r_s1.step >> 1);
        end
        if (r_s1.nib[2]) begin
            w_delta = w_delta + 13'(r_s1.step);
        end
    end

    // 14 bits hold any accumulator +/- delta, so the clamp sees the true sum.
    always_comb begin
        if (r_s1.nib[3]) begin
            w_sum = 14'(r_snd) - $signed({1'b0, w_delta});
        end else begin
            w_sum = 14'(r_snd) + $signed({1'b0, w_delta});
        end

        if (w_sum > 14'(SND_MAX)) begin
            w_snd_next = SND_MAX;
        end else if (w_sum < 14'(SND_MIN)) begin
            w_snd_next = SND_MIN;
        end else begin
            w_snd_next = w_sum[11:0];
        end
    end

    // Stage 2: accumulate into the held output sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snd       <= '0;
            r_sample_ok <= 1'b0;
        end else if (bus.pause) begin
            r_snd       <= '0;
            r_sample_ok <= 1'b0;
        end else begin
            r_sample_ok <= r_s1.valid;
            if (r_s1.valid) begin
                r_snd <= w_snd_next;
            end
        end
    end

    assign bus.sound     = r_snd;
    assign bus.sample_ok = r_sample_ok;

endmodule
`default_nettype wire

// File: doc/jt5205_adpcm.md
JT5205_ADPCM -- requirements
Module: jt5205_adpcm

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have the port cen_lo, input, 1 bit: one-clk sample strobe from the timing stage; one nibble is decoded per pulse.
REQ-004 The module SHALL have the port din, input, 4 bits: ADPCM nibble; bit 3 is the sign, bits 2:0 are the magnitude.
REQ-005 The module SHALL have the port pause, input, 1 bit: chip RESET pin equivalent; synchronous, active-high.
REQ-006 The module SHALL have the port sound, output, 12 bits signed: decoded sample, held between updates.
REQ-007 The module SHALL have the port sample_ok, output, 1 bit: one-clk pulse in the cycle sound takes a new value.

Function
REQ-008 The module SHALL keep a step index idx in the range 0..48 (6 bits) and a 12-bit signed accumulator snd.
REQ-009 The module SHALL use the standard 49-entry OKI step table, 16,17,19,...,1411,1552; each entry is 11 bits unsigned.
REQ-010 Stage 1, on the edge after a clk where cen_lo=1, SHALL latch din into nib and step=table[idx], and update idx at the same edge.
REQ-011 The idx update SHALL be idx+adj[din[2:0]], with adj = -1,-1,-1,-1,+2,+4,+6,+8, saturated to 0..48 (no wrap).
REQ-012 Stage 2, one clk after stage 1, SHALL form delta = step>>3, plus step>>2 if nib[0], plus step>>1 if nib[1], plus step if nib[2]; delta is unsigned, 13 bits.
REQ-013 Stage 2 SHALL compute snd_next = snd-delta if nib[3] is set, otherwise snd+delta.
REQ-014 The stage 2 sum SHALL be evaluated at 14 bits signed and clamped to -2048..+2047, with no wrap-around.
REQ-015 Stage 2 SHALL register snd_next into sound and pulse sample_ok for exactly one clk.
REQ-016 Latency SHALL be 2 clk from cen_lo to the sound update.
REQ-017 cen_lo pulses SHALL be accepted on consecutive clocks (fully pipelined), with no pulses dropped.
REQ-018 Each stage-2 update SHALL use the snd value produced by the preceding nibble.
REQ-019 When pause=1, the next edge SHALL set idx=0, snd=0, sound=0 and sample_ok=0, and SHALL cancel both pipeline stages.
REQ-020 While pause=1, cen_lo SHALL be ignored.
REQ-021 If pause=1 coincides with cen_lo or with stage-2 activity, pause SHALL win and no update SHALL occur.
REQ-022 While cen_lo=0 and no stage is active, all state SHALL hold.

Reset
REQ-023 rst=1 SHALL asynchronously clear idx, snd, nib, step, the stage-valid flags, sound and sample_ok to 0.
REQ-024 Assertion of rst mid-pipeline SHALL discard the in-flight nibble.
REQ-025 After rst is released, the first cen_lo SHALL decode with idx=0 (step 16).

Structure
REQ-026 The step table, the adj table, and the constants SND_MAX=2047, SND_MIN=-2048 and IDX_MAX=48 SHALL live in a shared jt5205 package/include, reused by the test bench model.
REQ-027 The step lookup SHALL be a separate sub-module jt5205_steptab: combinational 6-bit index to 11-bit step, synthesizable as a ROM.
REQ-028 Stage-valid flags SHALL be explicit registers; no combinational path from din to sound SHALL exist.

Verification
REQ-029 Scenario "first nibble": after rst, cen_lo with din=0 -> sound=2 two clk later, sample_ok pulse, idx=0 (clamped from -1).
REQ-030 Scenario "positive and negative": after rst, din=7 -> sound=30, idx=8; then din=8 -> sound=30-(step[8]>>3)=30-4=26, idx=7.
REQ-031 Scenario "saturation": repeated din=7 -> idx reaches 48 and stays there; sound reaches 2047 and stays there; then repeated din=15 -> sound reaches -2048 and stays there, with no wrap.
REQ-032 Scenario "back-to-back": cen_lo on 4 consecutive clk with din=4,4,4,4 -> 4 consecutive sample_ok pulses with values matching the package model.
REQ-033 Scenario "pause": pause=1 in the same clk as cen_lo -> no sample_ok, sound=0, idx=0; after release, din=0 -> sound=2.
REQ-034 Scenario "async reset mid-pipeline": rst asserted one clk after cen_lo -> sound=0 immediately, no sample_ok issued.
